uart_tx_dev: RTL and testbench
==============================

# uart_tx_dev

Memory-mapped UART transmitter peripheral sitting downstream of the system bridge, alongside the two timer devices. The CPU writes bytes through the bridge's device write port, and the block queues them in a small FIFO. It then serialises each byte 8N1 on `txd` at a programmable bit period. A level interrupt goes to one of the spare `HWInt` lines when the transmitter drains.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: entries in the transmit FIFO; power of two, ≥2.
- `DIV_RESET`, 16'd16: reset value of the DIVISOR register.

Ports:
- `clk` input 1: single clock.
- `reset` input 1: asynchronous, active-low (asserted at 0).
- `Addr` input 32: bridge device address; only `Addr[3:2]` decoded.
- `WE` input 1: write enable from bridge, already qualified for this device.
- `Din` input 32: write data from bridge.
- `Dout` output 32: read data to bridge; combinational from `Addr[3:2]` and current state.
- `IRQ` output 1: level interrupt request into `HWInt`.
- `txd` output 1: serial line; idle high.

## Operation
- Register map by `Addr[3:2]`:
  - 0 DATA. Write pushes `Din[7:0]` into the FIFO. Read returns {24'b0, FIFO head}, or 0 if empty.
  - 1 STATUS, read-only bits:
    - [0] busy (FSM not IDLE)
    - [1] full
    - [2] empty
    - [3] overflow (sticky)
    - [7:4] FIFO count
    - A write of any value clears overflow.
  - 2 CTRL, R/W bits:
    - [0] EN: transmitter enable
    - [1] IE: interrupt enable
    - other bits read 0.
  - 3 DIVISOR, R/W [15:0]: bit period in clk cycles; value 0 is treated as 1.
- FIFO behaviour:
  - Push to DATA when full, with no pop in the same cycle: byte is dropped and overflow is set.
  - Push and pop in the same cycle are both honoured; count stays unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when EN=1 and FIFO non-empty. On entry, the head byte is popped into the shift register and DIVISOR is latched into the frame period register.
  - START: `txd`=0 for one period → DATA.
  - DATA: 8 bits, LSB first, one period each. A 3-bit bit index counts 0..7, then → STOP.
  - STOP: `txd`=1 for one period. Then → START if EN and FIFO non-empty (back-to-back, no idle gap); otherwise → IDLE.
- Clearing EN mid-frame does not abort the frame: the current frame completes and no new frame starts.
- `IRQ` = IE & empty & (state==IDLE). It is registered, so it updates one cycle after the condition changes.

## Timing
- Reset values:
  - `txd`=1, `IRQ`=0, FSM=IDLE
  - FIFO empty, overflow=0
  - CTRL=0, DIVISOR=`DIV_RESET`
  - `Dout` follows from these values, e.g. STATUS reads 32'h4.
- Register writes take effect at the rising edge where `WE`=1.
- First start bit appears 1 cycle after the DATA write edge when EN=1 and the FSM is IDLE.
- Frame length is exactly 10×P cycles, where P = max(latched DIVISOR, 1).
- A DIVISOR write mid-frame affects only the next frame.
- The baud counter runs from P-1 down to 0. The bit advances on the cycle the counter is 0.
- Asynchronous reset mid-frame forces `txd`=1 immediately and discards the FIFO contents.

## Structure
- Shared package holds:
  - register offsets (DATA=2'd0, STATUS=2'd1, CTRL=2'd2, DIV=2'd3)
  - FSM state encoding
  - STATUS/CTRL bit positions
- One natural sub-module: `uart_fifo` (parameterised depth, 8-bit data, push/pop/full/empty/count).
- The shift/baud FSM and register file stay in `uart_tx_dev`.

## Test plan
- Reset, then read all four registers → DATA=0, STATUS=32'h4, CTRL=0, DIVISOR=16.
- Write DIVISOR=4, CTRL=1, DATA=8'hA5.
  - Expected `txd` from the next cycle: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1, then 1; 40 cycles total.
  - STATUS busy drops after cycle 40.
- CTRL=0, push 5 bytes → 5th dropped, STATUS=32'h4A (count 4, full, overflow). STATUS write clears overflow → 32'h42.
- CTRL=3 with 2 bytes queued and DIVISOR=2 → two back-to-back 20-cycle frames with no idle gap. `IRQ` rises 1 cycle after the second stop bit ends.
- Mid-frame DIVISOR write 2→6 → current frame keeps P=2; next frame uses P=6.
- Assert reset during the 3rd data bit → `txd`=1 within the same cycle; after release STATUS=32'h4 and `IRQ`=0.

Source files
------------

// File: rtl/uart_tx_dev_pkg.sv
// uart_tx_dev_pkg: register offsets, status/control bit positions and FSM encoding for the UART transmitter
package uart_tx_dev_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;
  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 4;
  localparam int CTRL_EN  = 0;
  localparam int CTRL_IE  = 1;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
  // A divisor of zero would stall the baud counter, so it runs as one cycle per bit.
  function automatic logic [15:0] bit_period(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: byte FIFO with head look-ahead; a push into a full FIFO is honoured only alongside a pop
module uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign head  = mem_q[rp_q];
  assign count = cnt_q;
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wp_d    = do_push ? wp_q + AW'(1) : wp_q;
    rp_d    = do_pop ? rp_q + AW'(1) : rp_q;
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter with FIFO, programmable bit period and drain interrupt
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d, period_q, period_d, div_q, div_d, p_new;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d, fifo_head;
  logic [1:0]    ctrl_q, ctrl_d, sel;
  logic          ovf_q, ovf_d, irq_q, irq_d, txd_q, txd_d;
  logic          wr_data, fifo_pop, fifo_full, fifo_empty, start_ok, done;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;
  logic          unused;
  assign unused   = ^{Addr[31:4], Addr[1:0], Din[31:16]};
  assign sel      = Addr[3:2];
  assign wr_data  = WE && sel == REG_DATA;
  assign done     = cnt_q == 16'd0;
  assign p_new    = bit_period(div_q);
  assign start_ok = ctrl_q[CTRL_EN] && !fifo_empty;
  assign IRQ      = irq_q;
  assign txd      = txd_q;
  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (wr_data),
    .pop   (fifo_pop),
    .din   (Din[7:0]),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    period_d = period_q;
    fifo_pop = 1'b0;
    cnt_d    = (state_q == S_IDLE) ? cnt_q : done ? period_q - 16'd1 : cnt_q - 16'd1;
    case (state_q)
      S_IDLE:  ;
      S_START: if (done) begin
        state_d = S_DATA;
        bit_d   = 3'd0;
      end
      S_DATA:  if (done) begin
        if (bit_q == 3'd7) state_d = S_STOP;
        else begin
          bit_d   = bit_q + 3'd1;
          shift_d = shift_q >> 1;
        end
      end
      S_STOP:  if (done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A frame starts from idle or directly off the last stop-bit cycle, so queued bytes go back-to-back.
    if (start_ok && (state_q == S_IDLE || (state_q == S_STOP && done))) begin
      state_d  = S_START;
      fifo_pop = 1'b1;
      shift_d  = fifo_head;
      period_d = p_new;
      cnt_d    = p_new - 16'd1;
    end
    txd_d = (state_d == S_START) ? 1'b0 : (state_d == S_DATA) ? shift_d[0] : 1'b1;
  end
  always_comb begin
    ctrl_d = (WE && sel == REG_CTRL) ? Din[1:0] : ctrl_q;
    div_d  = (WE && sel == REG_DIV) ? Din[15:0] : div_q;
    ovf_d  = (WE && sel == REG_STATUS) ? 1'b0 : (wr_data && fifo_full && !fifo_pop) ? 1'b1 : ovf_q;
    irq_d  = ctrl_q[CTRL_IE] && fifo_empty && state_q == S_IDLE;
    status = '0;
    status[ST_BUSY]       = state_q != S_IDLE;
    status[ST_FULL]       = fifo_full;
    status[ST_EMPTY]      = fifo_empty;
    status[ST_OVF]        = ovf_q;
    status[ST_CNT +: 4]   = 4'(fifo_count);
    Dout = (sel == REG_DATA)   ? (fifo_empty ? 32'd0 : {24'd0, fifo_head}) :
           (sel == REG_STATUS) ? status :
           (sel == REG_CTRL)   ? {30'd0, ctrl_q} : {16'd0, div_q};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= 16'd1;
      bit_q    <= '0;
      shift_q  <= '0;
      ctrl_q   <= '0;
      div_q    <= DIV_RESET;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      ctrl_q   <= ctrl_d;
      div_q    <= div_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      txd_q    <= txd_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: queue-based frame model checked every cycle, plus directed literal checks
module tb_uart_tx_dev;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Addr = 32'd0;
  logic        WE = 1'b0;
  logic [31:0] Din = 32'd0;
  logic [31:0] Dout;
  logic        IRQ, txd;
  int          checks = 0;
  int          failures = 0;
  bit          run = 1'b0;
  logic [7:0]  mq[$];
  bit          wave[$];
  bit          m_en = 0, m_ie = 0, m_ovf = 0, m_busy = 0, m_txd = 1, m_irq = 0;
  logic [15:0] m_div = 16'd16;
  int          mp;
  logic [7:0]  mb;

  uart_tx_dev #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd16)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .IRQ(IRQ), .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_dout();
    case (Addr[3:2])
      2'd0:    return mq.size() != 0 ? {24'd0, mq[0]} : 32'd0;
      2'd1:    return {24'd0, 4'(mq.size()), m_ovf, mq.size() == 0, mq.size() == DEPTH, m_busy};
      2'd2:    return {30'd0, m_ie, m_en};
      default: return {16'd0, m_div};
    endcase
  endfunction

  // Model: a frame is a list of per-cycle line levels; a new one may start whenever the list is spent.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      mq.delete(); wave.delete();
      m_en = 0; m_ie = 0; m_ovf = 0; m_busy = 0; m_txd = 1; m_irq = 0; m_div = 16'd16;
    end else begin
      m_irq = m_ie && mq.size() == 0 && !m_busy;
      if (wave.size() == 0 && m_en && mq.size() != 0) begin
        mp = (m_div == 16'd0) ? 1 : int'(m_div);
        mb = mq.pop_front();
        for (int i = 0; i < 10; i++)
          for (int j = 0; j < mp; j++)
            wave.push_back(i == 0 ? 1'b0 : i == 9 ? 1'b1 : mb[i-1]);
      end
      m_busy = wave.size() != 0;
      m_txd = m_busy ? wave.pop_front() : 1'b1;
      if (WE) begin
        case (Addr[3:2])
          2'd0: if (mq.size() < DEPTH) mq.push_back(Din[7:0]); else m_ovf = 1;
          2'd1: m_ovf = 0;
          2'd2: begin m_en = Din[0]; m_ie = Din[1]; end
          default: m_div = Din[15:0];
        endcase
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (run && reset) begin
      chk("txd", {31'd0, txd}, {31'd0, m_txd});
      chk("irq", {31'd0, IRQ}, {31'd0, m_irq});
      chk("dout", Dout, exp_dout());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'd0, a, 2'b00}; Din = d; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    Addr = {28'd0, a, 2'b00};
    #1 chk(name, Dout, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    logic [9:0]  fr;
    logic [19:0] two;
    fr  = 10'b1101001010;
    two = 20'b1110000110_1001111000;
    tick(); tick();
    reset = 1'b1;
    run = 1'b1;
    tick();
    rd(2'd0, 32'h0, "rst_data");
    rd(2'd1, 32'h4, "rst_status");
    rd(2'd2, 32'h0, "rst_ctrl");
    rd(2'd3, 32'd16, "rst_div");
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);

    wr(2'd3, 32'd4);
    wr(2'd2, 32'd1);
    wr(2'd0, 32'hA5);
    Addr = 32'h4;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("a5_txd", {31'd0, txd}, {31'd0, fr[(k-1)/4]});
      if (k == 40) chk("a5_busy_end", {31'd0, Dout[0]}, 32'd1);
    end
    tick();
    chk("a5_busy_drop", {31'd0, Dout[0]}, 32'd0);

    wr(2'd2, 32'd0);
    wr(2'd0, 32'h11); wr(2'd0, 32'h22); wr(2'd0, 32'h33); wr(2'd0, 32'h44); wr(2'd0, 32'h55);
    rd(2'd0, 32'h11, "ovf_head");
    rd(2'd1, 32'h4A, "ovf_status");
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h42, "ovf_clear");

    do_reset();
    wr(2'd3, 32'd2);
    wr(2'd0, 32'h3C);
    wr(2'd0, 32'hC3);
    wr(2'd2, 32'd3);
    Addr = 32'h4;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("b2b_txd", {31'd0, txd}, {31'd0, two[(k-1)/2]});
    end
    tick();
    chk("irq_lag", {31'd0, IRQ}, 32'd0);
    tick();
    chk("irq_rise", {31'd0, IRQ}, 32'd1);

    wr(2'd0, 32'h55);
    wr(2'd0, 32'h81);
    wr(2'd3, 32'd6);
    for (int k = 3; k <= 85; k++) begin
      tick();
      if (k == 20 || k == 27) chk("div_hi", {31'd0, txd}, 32'd1);
      if (k >= 21 && k <= 26) chk("div_start6", {31'd0, txd}, 32'd0);
    end

    wr(2'd0, 32'h00);
    Addr = 32'h4;
    for (int k = 1; k <= 20; k++) tick();
    chk("pre_rst_txd", {31'd0, txd}, 32'd0);
    #2 reset = 1'b0;
    #1 chk("async_rst_txd", {31'd0, txd}, 32'd1);
    chk("async_rst_status", Dout, 32'h4);
    @(posedge clk); #1;
    reset = 1'b1;
    #1 chk("post_rst_status", Dout, 32'h4);
    chk("post_rst_irq", {31'd0, IRQ}, 32'd0);
    tick(); tick();
    chk("post_rst_irq2", {31'd0, IRQ}, 32'd0);
    chk("post_rst_txd", {31'd0, txd}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
